// File: rtl/step_ctrl.sv
// Turns the slow divided clock or a debounced step button into single-cycle CPU
// enable pulses in the clk domain, and counts the pulses issued.
module step_ctrl #(
    parameter logic [19:0] DEBOUNCE_CNT = 20'd1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_in,
    input  logic        btn_step,
    input  logic        run_mode,
    output logic        cpu_en,
    output logic [15:0] step_cnt
);

    localparam logic [19:0] DC_LOAD = DEBOUNCE_CNT - 20'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_HELD  = 2'd2,
        S_REL   = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [19:0] dcnt, dcnt_nxt;
    logic        step_req;

    logic tick_s1, tick_s, tick_d;
    logic btn_s1, btn_s;
    logic mode_s1, mode_s;
    logic tick_rise;

    // Two-flop synchronisers; tick_d gives the previous synchronised tick level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_s1 <= 1'b0;
            tick_s  <= 1'b0;
            tick_d  <= 1'b0;
            btn_s1  <= 1'b0;
            btn_s   <= 1'b0;
            mode_s1 <= 1'b0;
            mode_s  <= 1'b0;
        end else begin
            tick_s1 <= tick_in;
            tick_s  <= tick_s1;
            tick_d  <= tick_s;
            btn_s1  <= btn_step;
            btn_s   <= btn_s1;
            mode_s1 <= run_mode;
            mode_s  <= mode_s1;
        end
    end

    assign tick_rise = tick_s & ~tick_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            dcnt  <= 20'd0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
        end
    end

    // Debounce: a press fires once after a stable-high window, and the
    // button must then be stably low for a full window before it re-arms.
    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        step_req  = 1'b0;
        case (state)
            S_IDLE: begin
                if (btn_s) begin
                    dcnt_nxt  = DC_LOAD;
                    state_nxt = S_PRESS;
                end
            end
            S_PRESS: begin
                if (!btn_s) begin
                    state_nxt = S_IDLE;
                end else if (dcnt == 20'd0) begin
                    state_nxt = S_HELD;
                    step_req  = 1'b1;
                end else begin
                    dcnt_nxt = dcnt - 20'd1;
                end
            end
            S_HELD: begin
                if (!btn_s) begin
                    dcnt_nxt  = DC_LOAD;
                    state_nxt = S_REL;
                end
            end
            S_REL: begin
                if (btn_s) begin
                    state_nxt = S_HELD;
                end else if (dcnt == 20'd0) begin
                    state_nxt = S_IDLE;
                end else begin
                    dcnt_nxt = dcnt - 20'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Unselected source is simply dropped, so pulses never queue up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_en   <= 1'b0;
            step_cnt <= 16'd0;
        end else begin
            cpu_en <= mode_s ? tick_rise : step_req;
            if (cpu_en)
                step_cnt <= step_cnt + 16'd1;
        end
    end

endmodule
